// File: rtl/auction_ctrl.sv
// Sealed-bid auction controller: collects one bid per bidder, presents winner, top bid and price.
// Optional second-price mode enabled by defining AUCTION_CTRL_SECOND_PRICE_EN (default: first-price).
module auction_ctrl #(
    parameter int N = 2,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         bid_valid,
    input  logic [W-1:0] bid_data,
    output logic         bid_ready,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] winner,
    output logic [W-1:0] winning_bid,
    output logic [W-1:0] price,
    output logic         busy,
    output logic [1:0]   state_dbg
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [N-1:0] LAST_BIDDER = {N{1'b1}};

    logic [1:0]   state;
    logic [N-1:0] count;
    logic [W-1:0] max_bid;
    logic [N-1:0] winner_q;
`ifdef AUCTION_CTRL_SECOND_PRICE_EN
    logic [W-1:0] second_bid;
`endif

    // Handshakes: a bid transfers on a cycle with bid_valid && bid_ready, a result on
    // res_valid && res_ready; ready/valid outputs depend on state only, never on the peer's signal.
    assign bid_ready   = (state == COLLECT);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign state_dbg   = state;
    assign winner      = winner_q;
    assign winning_bid = max_bid;
`ifdef AUCTION_CTRL_SECOND_PRICE_EN
    assign price       = second_bid;
`else
    assign price       = max_bid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            max_bid  <= '0;
            winner_q <= '0;
`ifdef AUCTION_CTRL_SECOND_PRICE_EN
            second_bid <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        count    <= '0;
                        max_bid  <= '0;
                        winner_q <= '0;
`ifdef AUCTION_CTRL_SECOND_PRICE_EN
                        second_bid <= '0;
`endif
                    end
                end
                COLLECT: begin
                    if (bid_valid) begin
                        count <= count + 1'b1;
                        // Strict compare keeps the lowest index on ties.
                        if (count == '0 || bid_data > max_bid) begin
                            max_bid  <= bid_data;
                            winner_q <= count;
`ifdef AUCTION_CTRL_SECOND_PRICE_EN
                            second_bid <= max_bid;
                        end else if (bid_data > second_bid) begin
                            second_bid <= bid_data;
`endif
                        end
                        if (count == LAST_BIDDER) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_auction_ctrl.sv
// Self-checking bench for auction_ctrl (N=2, W=4): directed auctions plus randomized ones
// checked against a whole-auction reference model.
module tb_auction_ctrl;

    localparam int N  = 2;
    localparam int W  = 4;
    localparam int NB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         bid_valid;
    logic [W-1:0] bid_data;
    logic         bid_ready;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] winner;
    logic [W-1:0] winning_bid;
    logic [W-1:0] price;
    logic         busy;
    logic [1:0]   state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [N+2*W-1:0] exp_q[$];
    logic [W-1:0]     bids[NB];
    int               gaps[NB];

    always #5 clk = ~clk;

    auction_ctrl #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bid_valid   (bid_valid),
        .bid_data    (bid_data),
        .bid_ready   (bid_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .winner      (winner),
        .winning_bid (winning_bid),
        .price       (price),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Whole-auction model: winner is the first index holding the maximum; the second price is
    // the largest bid among all other bidders.
    task automatic model_push;
        int w;
        int mx;
        int sp;
        w  = 0;
        mx = int'(bids[0]);
        for (int i = 1; i < NB; i++) begin
            if (int'(bids[i]) > mx) begin
                mx = int'(bids[i]);
                w  = i;
            end
        end
        sp = 0;
        for (int i = 0; i < NB; i++) begin
            if (i != w && int'(bids[i]) > sp) sp = int'(bids[i]);
        end
`ifndef AUCTION_CTRL_SECOND_PRICE_EN
        sp = mx;
`endif
        exp_q.push_back({w[N-1:0], mx[W-1:0], sp[W-1:0]});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_winner"}, 32'(winner), 0);
        check({tag, "_winning_bid"}, 32'(winning_bid), 0);
        check({tag, "_price"}, 32'(price), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_bid_ready"}, 32'(bid_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Pulses start, streams bids with the configured idle gaps, then waits (bounded) for res_valid.
    task automatic drive_auction(output int cyc);
        int c;
        start = 1'b1;
        c = 0;
        tick;
        start = 1'b0;
        c++;
        check("busy_collect", 32'(busy), 1);
        for (int i = 0; i < NB; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                bid_valid = 1'b0;
                tick;
                c++;
            end
            bid_valid = 1'b1;
            bid_data  = bids[i];
            check("bid_ready_collect", 32'(bid_ready), 1);
            tick;
            c++;
        end
        bid_valid = 1'b0;
        while (res_valid !== 1'b1 && c < 40) begin
            tick;
            c++;
        end
        cyc = c;
    endtask

    task automatic run_auction(input int hold);
        int c;
        int exp_lat;
        logic [N+2*W-1:0] e;
        model_push();
        exp_lat = NB + 1;
        for (int i = 0; i < NB; i++) exp_lat += gaps[i];
        drive_auction(c);
        check("latency", 32'(c), 32'(exp_lat));
        check("res_valid_done", 32'(res_valid), 1);
        check("bid_ready_done", 32'(bid_ready), 0);
        e = exp_q.pop_front();
        check("winner", 32'(winner), 32'(e[N+2*W-1:2*W]));
        check("winning_bid", 32'(winning_bid), 32'(e[2*W-1:W]));
        check("price", 32'(price), 32'(e[W-1:0]));
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            start     = 1'b1;
            tick;
            check("hold_res_valid", 32'(res_valid), 1);
            check("hold_winner", 32'(winner), 32'(e[N+2*W-1:2*W]));
            check("hold_winning_bid", 32'(winning_bid), 32'(e[2*W-1:W]));
            check("hold_price", 32'(price), 32'(e[W-1:0]));
        end
        res_ready = 1'b1;
        start     = 1'b1;
        tick;
        res_ready = 1'b0;
        start     = 1'b0;
        check("post_hs_res_valid", 32'(res_valid), 0);
        check("post_hs_busy", 32'(busy), 0);
        tick;
        check("idle_needs_start_busy", 32'(busy), 0);
        check("idle_needs_start_bid_ready", 32'(bid_ready), 0);
    endtask

    task automatic set_bids(input int b0, input int b1, input int b2, input int b3);
        bids[0] = b0[W-1:0];
        bids[1] = b1[W-1:0];
        bids[2] = b2[W-1:0];
        bids[3] = b3[W-1:0];
        for (int i = 0; i < NB; i++) gaps[i] = 0;
    endtask

    initial begin
        int c;
        rst       = 1'b1;
        start     = 1'b0;
        bid_valid = 1'b0;
        bid_data  = '0;
        res_ready = 1'b0;
        tick;
        tick;
        check_all_zero("reset");
        rst = 1'b0;
        tick;
        check("idle_busy", 32'(busy), 0);

        set_bids(3, 9, 5, 1);
        run_auction(0);

        set_bids(7, 7, 2, 7);
        run_auction(0);

        set_bids(0, 0, 0, 15);
        gaps[2] = 3;
        run_auction(0);

        set_bids(3, 9, 5, 1);
        run_auction(4);

        // Reset after the second accepted bid abandons the auction.
        start = 1'b1;
        tick;
        start     = 1'b0;
        bid_valid = 1'b1;
        bid_data  = 4'd5;
        tick;
        bid_data = 4'd6;
        tick;
        bid_valid = 1'b0;
        rst       = 1'b1;
        tick;
        rst = 1'b0;
        check_all_zero("rst_collect");
        for (int i = 0; i < 6; i++) tick;
        check("rst_collect_no_result", 32'(res_valid), 0);
        check("rst_collect_idle", 32'(busy), 0);

        set_bids(1, 2, 3, 4);
        run_auction(0);

        // Reset while a result is pending discards it.
        set_bids(8, 3, 12, 6);
        drive_auction(c);
        check("pre_rst_done", 32'(res_valid), 1);
        res_ready = 1'b0;
        rst       = 1'b1;
        tick;
        rst = 1'b0;
        check_all_zero("rst_done");
        tick;
        tick;
        check("rst_done_no_result", 32'(res_valid), 0);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < NB; i++) begin
                bids[i] = W'($urandom_range(0, 15));
                gaps[i] = int'($urandom_range(0, 2));
            end
            if (t % 3 == 0) begin
                for (int i = 0; i < NB; i++) bids[i] = W'($urandom_range(0, 2));
            end
            run_auction(int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
